// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU: iterative shift-add multiplier and restoring divider.
// Optional macro HILO_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module hilo_muldiv_ctrl #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         flush,
    input  logic         rd_hilo,
    output logic         busy,
    output logic         stall,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       acc_hi_q, acc_hi_d;
    logic [W-1:0]       acc_lo_q, acc_lo_d;
    logic [W-1:0]       opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed, sign1, sign2;
    logic [W-1:0]       abs1, abs2;
    logic [W:0]         add_sum, shifted, diff;
    logic               quo_bit;
    logic [2*W-1:0]     prod_fix;
`ifdef HILO_FAST_MUL_EN
    logic [2*W-1:0]     fast_prod;
`endif

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        sign1     = op_signed & in1[W-1];
        sign2     = op_signed & in2[W-1];
        abs1      = sign1 ? -in1 : in1;
        abs2      = sign2 ? -in2 : in2;
`ifdef HILO_FAST_MUL_EN
        fast_prod = {{W{1'b0}}, abs1} * {{W{1'b0}}, abs2};
`endif

        add_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // Remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
        shifted  = {acc_hi_q, acc_lo_q[W-1]};
        diff     = shifted - {1'b0, opnd_q};
        quo_bit  = ~diff[W];
        prod_fix = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            is_div_d = 1'b0;
                            neg_lo_d = sign1 ^ sign2;
                            neg_hi_d = 1'b0;
`ifdef HILO_FAST_MUL_EN
                            {acc_hi_d, acc_lo_d} = fast_prod;
                            state_d  = FIN;
`else
                            acc_hi_d = '0;
                            acc_lo_d = abs2;
                            opnd_d   = abs1;
                            cnt_d    = CNT_W'(W);
                            state_d  = CALC;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            if (in2 == '0) begin
                                acc_hi_d = in1;
                                acc_lo_d = '1;
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                                state_d  = FIN;
                            end else begin
                                acc_hi_d = '0;
                                acc_lo_d = abs1;
                                opnd_d   = abs2;
                                neg_lo_d = sign1 ^ sign2;
                                neg_hi_d = sign1;
                                cnt_d    = CNT_W'(W);
                                state_d  = CALC;
                            end
                        end
                        OP_MTHI: hi_d = in1;
                        OP_MTLO: lo_d = in1;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_hi_d = quo_bit ? diff[W-1:0] : shifted[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], quo_bit};
                    end else begin
                        acc_hi_d = add_sum[W:1];
                        acc_lo_d = {add_sum[0], acc_lo_q[W-1:1]};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
                        lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (start | rd_hilo);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: table vectors, random ops against a reference model,
// and hand-written flush / reset / stall sequences. Honours HILO_FAST_MUL_EN for expected latency.
module tb_hilo_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush, rd_hilo;
    logic [2:0]   op;
    logic [W-1:0] in1, in2;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    hilo_muldiv_ctrl #(.W(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
        .flush(flush), .rd_hilo(rd_hilo), .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] b);
        if ((o == 3'd2 || o == 3'd3) && b == 32'd0) return 1;
`ifdef HILO_FAST_MUL_EN
        if (o <= 3'd1) return 1;
`endif
        return W + 1;
    endfunction

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [31:0] q, r;
        case (o)
            3'd0: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Drive one mul/div op, then wait (bounded) for done and compare against the scoreboard head.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expv, input string name);
        exp_t e;
        exp_t got;
        int   j;
        int   busy_cnt;
        e.hi  = expv[63:32];
        e.lo  = expv[31:0];
        e.lat = exp_latency(o, b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        tick();
        start = 1'b0;
        j = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && j < 100) begin
            tick();
            j++;
            if (!done && busy) busy_cnt++;
        end
        if (!done) begin
            checkOutput({name, "_done_timeout"}, 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checkOutput({name, "_scoreboard_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            checkOutput({name, "_latency"}, 64'(j), 64'(got.lat));
            checkOutput({name, "_busy_cycles"}, 64'(busy_cnt), 64'(got.lat));
            checkOutput({name, "_hi"}, {32'd0, hi}, {32'd0, got.hi});
            checkOutput({name, "_lo"}, {32'd0, lo}, {32'd0, got.lo});
            tick();
            checkOutput({name, "_done_pulse"}, {63'd0, done}, 64'd0);
        end
    endtask

    task automatic mtWrite(input logic [2:0] o, input logic [31:0] a, input logic fl);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; flush = fl;
        tick();
        start = 1'b0; flush = 1'b0;
    endtask

    localparam logic [2:0] FLUSH_OP =
`ifdef HILO_FAST_MUL_EN
        3'd3;
`else
        3'd1;
`endif

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          k;
        bit          done_seen;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{3'd3, 32'd100,       32'd7,        32'd2,         32'd14};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd2, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        vecs[5]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[6]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1};
        vecs[7]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[10] = '{3'd1, 32'h1234_5678, 32'h10,       32'd1,         32'h2345_6780};
        vecs[11] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2};
        vecs[12] = '{3'd0, 32'd6,         32'd7,        32'd0,         32'd42};

        reset = 1'b1; start = 1'b0; flush = 1'b0; rd_hilo = 1'b0;
        op = 3'd7; in1 = '0; in2 = '0;
        tick();
        tick();
        checkOutput("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        checkOutput("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b,
                          {vecs[i].exp_hi, vecs[i].exp_lo}, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", i));
        end

        mtWrite(3'd5, 32'h0000_ABCD, 1'b0);
        checkOutput("mtlo_lo", {32'd0, lo}, 64'h0000_ABCD);
        checkOutput("mtlo_busy", {63'd0, busy}, 64'd0);
        mtWrite(3'd4, 32'h1111_1111, 1'b0);
        checkOutput("mthi_hi", {32'd0, hi}, 64'h1111_1111);
        rd_hilo = 1'b1;
        #1;
        checkOutput("idle_rd_stall", {63'd0, stall}, 64'd0);
        rd_hilo = 1'b0;

        mtWrite(3'd4, 32'hFFFF_0000, 1'b1);
        checkOutput("flush_mthi_hi", {32'd0, hi}, 64'h1111_1111);
        mtWrite(3'd0, 32'd3, 1'b1);
        checkOutput("flush_start_busy", {63'd0, busy}, 64'd0);

        // MTHI and MFHI while a divide is in flight
        @(negedge clk);
        start = 1'b1; op = 3'd3; in1 = 32'd100; in2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1; op = 3'd4; in1 = 32'hDEAD_BEEF;
        #1;
        checkOutput("busy_mthi_stall", {63'd0, stall}, 64'd1);
        tick();
        start = 1'b0; rd_hilo = 1'b1;
        #1;
        checkOutput("busy_rd_stall", {63'd0, stall}, 64'd1);
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        checkOutput("busy_div_done", {63'd0, done}, 64'd1);
        checkOutput("busy_rd_stall_after", {63'd0, stall}, 64'd0);
        checkOutput("busy_div_result", {hi, lo}, {32'd2, 32'd14});
        rd_hilo = 1'b0;

        // Flush in the middle of CALC
        mtWrite(3'd4, 32'h1111_1111, 1'b0);
        mtWrite(3'd5, 32'h2222_2222, 1'b0);
        @(negedge clk);
        start = 1'b1; op = FLUSH_OP; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_busy", {63'd0, busy}, 64'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        checkOutput("flush_no_done", {63'd0, done_seen}, 64'd0);
        checkOutput("flush_hilo_kept", {hi, lo}, {32'h1111_1111, 32'h2222_2222});

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd2; in1 = 32'hFFFF_FFF9; in2 = 32'd2;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rd_hilo = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checkOutput("midop_reset", {29'd0, busy, done, stall, hi}, 64'd0);
        checkOutput("midop_reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0; rd_hilo = 1'b0;
        repeat (40) tick();
        checkOutput("midop_reset_no_write", {hi, lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
